// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word/line payloads and the arbiter state encoding.
package lc3b_types;

    localparam int unsigned WORD_W       = 16;
    localparam int unsigned LINE_W_DFLT  = 128;

    typedef logic [WORD_W-1:0]      lc3b_word;
    typedef logic [LINE_W_DFLT-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter in front of a single physical memory port.
// Dcache wins ties by default; define ARB_ROUND_ROBIN_EN to alternate grants on ties.
// Grants take one cycle from IDLE, resp passes through with no added latency, and
// every completed transfer is followed by one IDLE cycle.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_read,
    input  lc3b_word          icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  lc3b_word          dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output lc3b_word          pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state;
    arb_state_t state_next;

    logic dcache_req;
    logic icache_req;
    logic pick_icache_on_tie;

    assign dcache_req = dcache_read | dcache_write;
    assign icache_req = icache_read;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 favours dcache on the next tie, 1 favours icache; flips to the side not just served.
    logic last_grant;

    // Tie-break history, updated on every completed transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b0;
        end else if (pmem_resp && (state != IDLE)) begin
            last_grant <= (state == SERVE_D);
        end
    end

    assign pick_icache_on_tie = last_grant;
`else
    assign pick_icache_on_tie = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: grant from IDLE, hold the grant until pmem_resp.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dcache_req && icache_req) begin
                    state_next = pick_icache_on_tie ? SERVE_I : SERVE_D;
                end else if (dcache_req) begin
                    state_next = SERVE_D;
                end else if (icache_req) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: steer the granted requester onto the memory port.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;
        icache_rdata = pmem_rdata;
        dcache_rdata = pmem_rdata;
        case (state)
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = icache_address;
                icache_resp  = pmem_resp;
            end
            SERVE_D: begin
                // Read and write together is treated as a write.
                pmem_read    = dcache_read & ~dcache_write;
                pmem_write   = dcache_write;
                pmem_address = dcache_address;
                pmem_wdata   = dcache_wdata;
                dcache_resp  = pmem_resp;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// transaction loop checked against a grant-order model.
module tb_mem_arbiter;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned GD = 0;   // dcache served
    localparam int unsigned GI = 1;   // icache served
    localparam int unsigned GN = 2;   // nothing served since reset

    logic              clk;
    logic              rst;
    logic              icache_read;
    logic [15:0]       icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [15:0]       dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [15:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int total = 0;
    int bad   = 0;
    int last_served = GN;

    mem_arbiter #(.LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; icache_read = 1'b1; dcache_read = 1'b1; dcache_write = 1'b0;
        icache_address = 16'h0; dcache_address = 16'h0; dcache_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        tick(); tick();
        #1;
        total++;
        if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0000", {pmem_read, pmem_write, icache_resp, dcache_resp});
        end
        icache_read = 1'b0; dcache_read = 1'b0;
        rst = 1'b0;
        last_served = GN;
        tick();
    endtask

    task automatic test_icache_read();
        logic [LINE_W-1:0] line;
        line = {16{8'hA5}};
        icache_read = 1'b1; icache_address = 16'h0060;
        #1;
        total++;
        if (pmem_read !== 1'b0) begin
            bad++; $display("FAIL ird_same_cycle pmem_read=%b want=0", pmem_read);
        end
        tick();
        total++;
        if ({pmem_read, pmem_write, pmem_address} !== {1'b1, 1'b0, 16'h0060}) begin
            bad++; $display("FAIL ird_grant rd=%b wr=%b addr=%h want 1 0 0060", pmem_read, pmem_write, pmem_address);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (icache_resp !== 1'b0) begin
                bad++; $display("FAIL ird_wait%0d icache_resp=%b want=0", k, icache_resp);
            end
            tick();
        end
        pmem_resp = 1'b1; pmem_rdata = line;
        #1;
        total++;
        if ({icache_resp, dcache_resp} !== 2'b10 || icache_rdata !== line) begin
            bad++; $display("FAIL ird_resp iresp=%b dresp=%b data=%h want 1 0 %h", icache_resp, dcache_resp, icache_rdata, line);
        end
        tick();
        pmem_resp = 1'b0; icache_read = 1'b0;
        #1;
        total++;
        if ({pmem_read, pmem_write, icache_resp} !== 3'b000) begin
            bad++; $display("FAIL ird_idle got=%b want=000", {pmem_read, pmem_write, icache_resp});
        end
        last_served = GI;
        tick();
    endtask

    task automatic test_dcache_write();
        logic [LINE_W-1:0] wd;
        wd = 128'hDEAD_BEEF_0000_0000_1111_2222_3333_4444;
        dcache_write = 1'b1; dcache_address = 16'h1230; dcache_wdata = wd;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({pmem_write, pmem_read, pmem_address} !== {1'b1, 1'b0, 16'h1230} || pmem_wdata !== wd || dcache_resp !== 1'b0) begin
                bad++; $display("FAIL dwr_cycle%0d wr=%b rd=%b addr=%h wdata=%h dresp=%b", k, pmem_write, pmem_read, pmem_address, pmem_wdata, dcache_resp);
            end
            tick();
        end
        pmem_resp = 1'b1;
        #1;
        total++;
        if ({dcache_resp, icache_resp} !== 2'b10) begin
            bad++; $display("FAIL dwr_resp got=%b want=10", {dcache_resp, icache_resp});
        end
        tick();
        pmem_resp = 1'b0; dcache_write = 1'b0;
        last_served = GD;
        tick();
    endtask

    // Both strobes rising together: order follows the configured tie rule.
    task automatic test_tie();
        int order [4];
        int n;
        icache_read = 1'b1; icache_address = 16'h0A00;
        dcache_read = 1'b1; dcache_address = 16'h0D00;
`ifdef ARB_ROUND_ROBIN_EN
        rst = 1'b1; tick(); rst = 1'b0; last_served = GN;
        n = 4;
        order = '{GD, GI, GD, GI};
`else
        n = 2;
        order = '{GD, GI, GD, GI};
`endif
        for (int t = 0; t < n; t++) begin
            tick();
            total++;
            if (pmem_address !== ((order[t] == GD) ? 16'h0D00 : 16'h0A00)) begin
                bad++; $display("FAIL tie_grant%0d addr=%h want_side=%0d", t, pmem_address, order[t]);
            end
            pmem_resp = 1'b1;
            #1;
            total++;
            if ({dcache_resp, icache_resp} !== ((order[t] == GD) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL tie_resp%0d d/i=%b side=%0d", t, {dcache_resp, icache_resp}, order[t]);
            end
            tick();
            pmem_resp = 1'b0;
            if (order[t] == GD && n == 2) begin
                dcache_read = 1'b0;
            end
            if (t == n - 1) begin
                icache_read = 1'b0; dcache_read = 1'b0;
            end
            #1;
            total++;
            if ({pmem_read, pmem_write} !== 2'b00) begin
                bad++; $display("FAIL tie_idle%0d got=%b want=00", t, {pmem_read, pmem_write});
            end
            last_served = order[t];
        end
        tick();
    endtask

    task automatic test_rw_both();
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h0002;
        tick();
        total++;
        if ({pmem_write, pmem_read, pmem_address} !== {1'b1, 1'b0, 16'h0002}) begin
            bad++; $display("FAIL rw_both wr=%b rd=%b addr=%h want 1 0 0002", pmem_write, pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        last_served = GD;
        tick();
    endtask

    task automatic test_reset_mid();
        dcache_read = 1'b1; dcache_address = 16'h4444;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; dcache_read = 1'b0; pmem_resp = 1'b1;
        last_served = GN;
        #1;
        total++;
        if ({dcache_resp, pmem_read, pmem_write} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_resp got=%b want=000", {dcache_resp, pmem_read, pmem_write});
        end
        tick();
        pmem_resp = 1'b0;
        #1;
        total++;
        if ({dcache_resp, icache_resp, pmem_read, pmem_write} !== 4'b0000) begin
            bad++; $display("FAIL rst_mid_after got=%b want=0000", {dcache_resp, icache_resp, pmem_read, pmem_write});
        end
        tick();
    endtask

    task automatic test_idle_resp();
        pmem_resp = 1'b1;
        #1;
        total++;
        if ({icache_resp, dcache_resp} !== 2'b00) begin
            bad++; $display("FAIL idle_resp got=%b want=00", {icache_resp, dcache_resp});
        end
        tick();
        pmem_resp = 1'b0;
        icache_read = 1'b1; icache_address = 16'h0BAD;
        #1;
        total++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            bad++; $display("FAIL idle_resp_state got=%b want=00", {pmem_read, pmem_write});
        end
        tick();
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0BAD) begin
            bad++; $display("FAIL idle_resp_regrant rd=%b addr=%h want 1 0bad", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; icache_read = 1'b0;
        last_served = GI;
        tick();
    endtask

    // Random traffic: the model picks each winner from who is waiting and who went last.
    task automatic test_random();
        int g, lat;
        logic [15:0] ia, da;
        logic er, ew;
        logic [LINE_W-1:0] wd, rd;
        int kind;
        for (int it = 0; it < 60; it++) begin
            if (!icache_read && ($urandom % 2 == 0)) begin
                ia = 16'($urandom); icache_address = ia; icache_read = 1'b1;
            end
            if (!(dcache_read | dcache_write) && ($urandom % 2 == 0)) begin
                kind = int'($urandom_range(0, 2));
                da = 16'($urandom); wd = rand_line();
                dcache_address = da; dcache_wdata = wd;
                dcache_read  = (kind != 1);
                dcache_write = (kind != 0);
            end
            ia = icache_address; da = dcache_address; wd = dcache_wdata;
            ew = dcache_write; er = dcache_read & ~dcache_write;
            if (!icache_read && !(dcache_read | dcache_write)) begin
                tick();
                total++;
                if ({pmem_read, pmem_write} !== 2'b00) begin
                    bad++; $display("FAIL rnd_quiet%0d got=%b want=00", it, {pmem_read, pmem_write});
                end
                continue;
            end
            if (!icache_read) g = GD;
            else if (!(dcache_read | dcache_write)) g = GI;
`ifdef ARB_ROUND_ROBIN_EN
            else g = (last_served == GD) ? GI : GD;
`else
            else g = GD;
`endif
            tick();
            total++;
            if (g == GD) begin
                if ({pmem_read, pmem_write, pmem_address} !== {er, ew, da} || (ew && pmem_wdata !== wd)) begin
                    bad++; $display("FAIL rnd_d%0d rd=%b wr=%b addr=%h want %b %b %h", it, pmem_read, pmem_write, pmem_address, er, ew, da);
                end
            end else begin
                if ({pmem_read, pmem_write, pmem_address} !== {1'b1, 1'b0, ia}) begin
                    bad++; $display("FAIL rnd_i%0d rd=%b wr=%b addr=%h want 1 0 %h", it, pmem_read, pmem_write, pmem_address, ia);
                end
            end
            lat = int'($urandom_range(0, 3));
            for (int k = 0; k < lat; k++) begin
                total++;
                if ({icache_resp, dcache_resp} !== 2'b00) begin
                    bad++; $display("FAIL rnd_wait%0d got=%b want=00", it, {icache_resp, dcache_resp});
                end
                tick();
            end
            rd = rand_line();
            pmem_rdata = rd; pmem_resp = 1'b1;
            #1;
            total++;
            if ({dcache_resp, icache_resp} !== ((g == GD) ? 2'b10 : 2'b01) ||
                ((g == GD) ? dcache_rdata : icache_rdata) !== rd) begin
                bad++; $display("FAIL rnd_resp%0d d/i=%b side=%0d", it, {dcache_resp, icache_resp}, g);
            end
            tick();
            pmem_resp = 1'b0;
            if (g == GD) begin
                dcache_read = 1'b0; dcache_write = 1'b0;
            end else begin
                icache_read = 1'b0;
            end
            last_served = g;
            #1;
            total++;
            if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0000) begin
                bad++; $display("FAIL rnd_gap%0d got=%b want=0000", it, {pmem_read, pmem_write, icache_resp, dcache_resp});
            end
        end
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_tie();
        test_rw_both();
        test_reset_mid();
        test_idle_resp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 128, meaning the width in bits of a cache-line transfer.
REQ-002 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have ports icache_read (in, 1), icache_address (in, lc3b_word), icache_rdata (out, LINE_W) and icache_resp (out, 1) for the instruction-side requester, which is read-only.
REQ-005 SHALL have ports dcache_read (in, 1), dcache_write (in, 1), dcache_address (in, lc3b_word), dcache_wdata (in, LINE_W), dcache_rdata (out, LINE_W) and dcache_resp (out, 1) for the data-side requester.
REQ-006 SHALL have ports pmem_read (out, 1), pmem_write (out, 1), pmem_address (out, lc3b_word), pmem_wdata (out, LINE_W), pmem_rdata (in, LINE_W) and pmem_resp (in, 1) for the physical memory side.

Function
REQ-007 SHALL use the FSM states IDLE, SERVE_I and SERVE_D, with the state held in a register.
REQ-008 In IDLE, SHALL drive pmem_read and pmem_write to 0 and both resp outputs to 0.
REQ-009 In IDLE, with a dcache request (read|write) pending: next state SERVE_D. With only an icache request pending: next state SERVE_I. With no request: stay in IDLE.
REQ-010 If both requesters are pending in IDLE, SHALL grant dcache (fixed priority) unless ARB_ROUND_ROBIN_EN is defined (REQ-020).
REQ-011 In SERVE_I, SHALL drive pmem_read=1, pmem_write=0 and pmem_address=icache_address combinationally.
REQ-012 In SERVE_D, SHALL drive pmem_read=dcache_read&~dcache_write, pmem_write=dcache_write, pmem_address=dcache_address and pmem_wdata=dcache_wdata; if read and write are both set, it SHALL be treated as a write.
REQ-013 SHALL pass pmem_rdata to both rdata outputs at all times; only the granted requester's resp qualifies the data.
REQ-014 SHALL drive the granted requester's resp equal to pmem_resp in the same cycle (zero added latency), and SHALL hold the ungranted resp at 0.
REQ-015 On pmem_resp in a SERVE state, the next state SHALL be IDLE, giving one mandatory IDLE cycle between transfers.
REQ-016 Grant latency from a request asserted in IDLE to pmem_read/pmem_write asserted SHALL be exactly 1 cycle.
REQ-017 Requesters SHALL hold address, data and strobes stable until they see resp; the arbiter SHALL NOT re-sample the grant while in a SERVE state.
REQ-018 A requester that drops its strobe while in SERVE_x SHALL be an illegal condition; the arbiter SHALL stay in SERVE_x until pmem_resp regardless.
REQ-019 pmem_resp seen in IDLE SHALL be ignored, with no resp asserted and no state change.

Configuration
REQ-020 With ARB_ROUND_ROBIN_EN defined, SHALL keep a 1-bit last_grant register (reset 0 = dcache); on a tie in IDLE it SHALL grant the requester not served last, and last_grant SHALL update on every pmem_resp completion.
REQ-021 Without ARB_ROUND_ROBIN_EN, SHALL have no last_grant register and fixed dcache priority per REQ-010.

Reset
REQ-022 With rst=1 at a clock edge, the next state SHALL be IDLE (and last_grant 0 if present), so pmem_read, pmem_write and both resp outputs are 0 from the following cycle.
REQ-023 Reset mid-transfer SHALL abandon the transfer without issuing resp; pmem_resp arriving afterwards SHALL be ignored per REQ-019.

Structure
REQ-024 The types lc3b_word and lc3b_line (LINE_W bits) and the enum arb_state_t {IDLE, SERVE_I, SERVE_D} SHALL live in package lc3b_types.
REQ-025 SHALL be a single module with no sub-modules, split into a state register block, a next-state block and an output block.

Verification
REQ-026 icache_read=1, address 0x0060; memory responds after 3 cycles with 0xA5A5...A5 -> pmem_read is high 1 cycle after the request, icache_resp pulses 1 cycle with that rdata, then 1 IDLE cycle follows.
REQ-027 dcache_write=1, address 0x1230, wdata 0xDEAD_BEEF_0000_0000_1111_2222_3333_4444 -> pmem_write=1, pmem_read=0, and the pmem address and data match the inputs until pmem_resp.
REQ-028 icache and dcache requests in the same cycle, fixed priority -> dcache is served first, then icache; icache_resp never asserts during SERVE_D.
REQ-029 ARB_ROUND_ROBIN_EN defined, both requesting continuously for 4 transfers -> grants alternate D, I, D, I.
REQ-030 rst=1 asserted 2 cycles into SERVE_D, with pmem_resp arriving 1 cycle later -> the FSM is IDLE, and dcache_resp, pmem_read and pmem_write all stay 0.
REQ-031 dcache_read=1 and dcache_write=1 together at address 0x0002 -> a write is issued (pmem_write=1, pmem_read=0).
